minmax_tracker4: RTL

//  Streaming min/max tracker for WIDTH-bit unsigned samples. The magnitude-compare stage sits

---
 rtl/minmax_tracker4_if.sv | 27 ++
 rtl/minmax_tracker4.sv | 83 ++++++++
 2 files changed

// File: rtl/minmax_tracker4_if.sv
// Handshake and result bundle of the streaming min/max tracker.
// The master side feeds frames; the slave side is the tracker itself.
interface minmax_tracker4_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] min_val;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, max_val, min_val, count, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, max_val, min_val, count, busy, done
    );
endinterface

// File: rtl/minmax_tracker4.sv
// Per-frame running max/min/sample-count tracker for unsigned samples.
// A frame runs from start to the in_last beat; results hold until the next start.
module minmax_tracker4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    minmax_tracker4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] max_q, min_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q, busy_q, done_q;
    logic             beat;

    // ready_q is high exactly in RUN, so this is the accept condition
    assign beat = bus.in_valid & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            max_q   <= '0;
            min_q   <= ALL_ONE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        max_q   <= '0;
                        min_q   <= ALL_ONE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (beat) begin
                        // first beat seeds both extremes regardless of their cleared values
                        if (cnt_q == '0) begin
                            max_q <= bus.in_data;
                            min_q <= bus.in_data;
                        end else begin
                            if (bus.in_data > max_q) max_q <= bus.in_data;
                            if (bus.in_data < min_q) min_q <= bus.in_data;
                        end
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                        if (bus.in_last) begin
                            state   <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.max_val  = max_q;
    assign bus.min_val  = min_q;
    assign bus.count    = cnt_q;
    assign bus.in_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
